// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions.
//   NUM_ROUNDS_DEF : default number of round keys after the cipher key
//   state_t        : key-expansion FSM encoding (IDLE / EXPAND)
//   rcon()         : round constant (top byte of the Rcon word) for round i
package aes_pkg;

  localparam int NUM_ROUNDS_DEF = 10;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  // Rcon[i] for i = 1..10. Any other index returns zero.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_expansion_if.sv
// Bundle of the key_expansion request/response signals.
//   START      : one-cycle expansion request, sampled only while idle
//   IN_KEY     : 128-bit cipher key, captured on the accepted START edge
//   KEY_SEL    : round-key index to read
//   ROUND_KEY  : registered key[KEY_SEL]
//   BUSY/DONE/KEYS_VALID : expansion status
// Handshake: there is no ready signal. A START pulse is taken only when the
// expander is idle (BUSY low, or the cycle DONE is high); a START while an
// expansion runs is dropped. Consumers treat ROUND_KEY as meaningful only
// while KEYS_VALID is high.
interface key_expansion_if;
  logic         START;
  logic [127:0] IN_KEY;
  logic [3:0]   KEY_SEL;
  logic [127:0] ROUND_KEY;
  logic         BUSY;
  logic         DONE;
  logic         KEYS_VALID;

  modport master (
    output START, IN_KEY, KEY_SEL,
    input  ROUND_KEY, BUSY, DONE, KEYS_VALID
  );

  modport slave (
    input  START, IN_KEY, KEY_SEL,
    output ROUND_KEY, BUSY, DONE, KEYS_VALID
  );
endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
//   in_byte  : byte to substitute
//   out_byte : S-box(in_byte)
// Built from the S-box definition (GF(2^8) inverse followed by the affine
// transform) rather than a 256-entry table; zero maps to zero through the
// inverse because 0^254 = 0.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Inverse as x^254 via a short addition chain.
  always_comb begin
    x2   = gf_mul(in_byte, in_byte);
    x3   = gf_mul(x2, in_byte);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
  end

  // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  assign out_byte = inv
                  ^ {inv[6:0], inv[7]}
                  ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule with a stored round-key file.
//   clk, rst_n  : clock, asynchronous active-low reset
//   START       : accepted only in IDLE; loads IN_KEY into key[0]
//   IN_KEY      : cipher key, w0 = IN_KEY[127:96]
//   KEY_SEL     : read index; ROUND_KEY = key[KEY_SEL] one cycle later,
//                 zero when KEY_SEL > NUM_ROUNDS
//   ROUND_KEY   : registered round key
//   BUSY        : high from the START edge through the cycle after the last
//                 key write (NUM_ROUNDS+1 cycles)
//   DONE        : one-cycle pulse after key[NUM_ROUNDS] is written
//   KEYS_VALID  : full key set stored; cleared by an accepted START
// One round key is produced per cycle; key[i] is written on edge START+i.
module key_expansion
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         START,
  input  logic [127:0] IN_KEY,
  input  logic [3:0]   KEY_SEL,
  output logic [127:0] ROUND_KEY,
  output logic         BUSY,
  output logic         DONE,
  output logic         KEYS_VALID
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  state_t       state;
  state_t       state_next;
  logic [3:0]   round_cnt;
  logic [127:0] key_mem [0:NUM_ROUNDS];

  logic         load_key;
  logic         step_key;
  logic         last_step;

  logic [3:0]   prev_idx;
  logic [3:0]   sel_idx;
  logic [127:0] prev_key;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  temp;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] next_key;

  // ---------------- next-key datapath ----------------
  // round_cnt is 0 only in IDLE, where the datapath result is unused; the
  // clamp keeps the read index inside the key file.
  assign prev_idx = (round_cnt == 4'd0) ? 4'd0 : round_cnt - 4'd1;
  assign prev_key = key_mem[prev_idx];
  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .in_byte  (rot_word[8*b +: 8]),
      .out_byte (sub_word[8*b +: 8])
    );
  end

  assign temp     = sub_word ^ {rcon(round_cnt), 24'h000000};
  assign w0_n     = prev_key[127:96] ^ temp;
  assign w1_n     = prev_key[95:64]  ^ w0_n;
  assign w2_n     = prev_key[63:32]  ^ w1_n;
  assign w3_n     = prev_key[31:0]   ^ w2_n;
  assign next_key = {w0_n, w1_n, w2_n, w3_n};

  // Out-of-range selects are forced to zero at the register; the clamp only
  // keeps the array read in bounds.
  assign sel_idx  = (KEY_SEL > LAST) ? 4'd0 : KEY_SEL;

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = EXPAND;
      EXPAND:  if (round_cnt == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs / controls ----------------
  always_comb begin
    load_key  = (state == IDLE) && START;
    step_key  = (state == EXPAND);
    last_step = (state == EXPAND) && (round_cnt == LAST);
  end

  // ---------------- state and storage ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      round_cnt  <= 4'd0;
      ROUND_KEY  <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      KEYS_VALID <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) key_mem[i] <= '0;
    end else begin
      state <= state_next;
      DONE  <= last_step;
      // Stays high on the last write edge so BUSY also covers the DONE cycle.
      BUSY  <= load_key | step_key;

      if (load_key) begin
        key_mem[0] <= IN_KEY;
        round_cnt  <= 4'd1;
        KEYS_VALID <= 1'b0;
      end else if (step_key) begin
        key_mem[round_cnt] <= next_key;
        round_cnt          <= last_step ? 4'd0 : round_cnt + 4'd1;
        if (last_step) KEYS_VALID <= 1'b1;
      end

      ROUND_KEY <= (KEY_SEL > LAST) ? '0 : key_mem[sel_idx];
    end
  end

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: FIPS-197 and all-zero key vectors,
// status timing, ignored START, mid-expansion reset, out-of-range select and
// back-to-back START on the DONE cycle.
module tb_key_expansion;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_KEY = 128'h0;
  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk;
  logic rst_n;

  key_expansion_if bus ();

  key_expansion #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .START      (bus.START),
    .IN_KEY     (bus.IN_KEY),
    .KEY_SEL    (bus.KEY_SEL),
    .ROUND_KEY  (bus.ROUND_KEY),
    .BUSY       (bus.BUSY),
    .DONE       (bus.DONE),
    .KEYS_VALID (bus.KEYS_VALID)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive KEY_SEL just after an edge, push the expected key, then compare
  // ROUND_KEY just after the following edge.
  task automatic read_key(input string tag, input logic [3:0] sel,
                          input logic [127:0] exp);
    @(posedge clk); #1;
    bus.KEY_SEL = sel;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    check_val(tag, bus.ROUND_KEY, exp_q.pop_front());
  endtask

  // Returns in cycle 1 (just after the edge that samples START).
  task automatic start_exp(input logic [127:0] key);
    @(posedge clk); #1;
    bus.IN_KEY = key;
    bus.START  = 1'b1;
    @(posedge clk); #1;
    bus.START  = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.DONE && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("done_seen", 128'(bus.DONE), 128'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_round_key"}, bus.ROUND_KEY, 128'h0);
    check_val({tag, "_busy"},  128'(bus.BUSY), 128'(0));
    check_val({tag, "_done"},  128'(bus.DONE), 128'(0));
    check_val({tag, "_valid"}, 128'(bus.KEYS_VALID), 128'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    rst_n       = 1'b0;
    bus.START   = 1'b0;
    bus.IN_KEY  = '0;
    bus.KEY_SEL = 4'd0;

    // Reset state.
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Timing with the FIPS key: START sampled at cycle 0 edge.
    start_exp(FIPS_KEY);
    for (int k = 1; k <= 13; k++) begin
      check_val($sformatf("busy_c%0d", k),  128'(bus.BUSY),       128'(k <= 11));
      check_val($sformatf("done_c%0d", k),  128'(bus.DONE),       128'(k == 11));
      check_val($sformatf("valid_c%0d", k), 128'(bus.KEYS_VALID), 128'(k >= 11));
      @(posedge clk); #1;
    end
    read_key("fips_k0",  4'd0,  FIPS_KEY);
    read_key("fips_k1",  4'd1,  FIPS_K1);
    read_key("fips_k10", 4'd10, FIPS_K10);

    // IN_KEY changes without START leave the key file alone.
    bus.IN_KEY = 128'hdeadbeef_00112233_44556677_8899aabb;
    repeat (3) @(posedge clk);
    #1;
    read_key("idle_hold_k0", 4'd0, FIPS_KEY);

    // All-zero key.
    start_exp(ZERO_KEY);
    wait_done(cyc);
    read_key("zero_k0",  4'd0,  ZERO_KEY);
    read_key("zero_k1",  4'd1,  ZERO_K1);
    read_key("zero_k10", 4'd10, ZERO_K10);

    // START at cycle 4 of an expansion with a different key is ignored.
    start_exp(FIPS_KEY);
    repeat (3) @(posedge clk);
    #1;
    bus.IN_KEY = ZERO_KEY;
    bus.START  = 1'b1;
    @(posedge clk); #1;
    bus.START  = 1'b0;
    wait_done(cyc);
    check_val("ignored_start_done_cycle", 128'(cyc + 5), 128'(11));
    @(posedge clk); #1;
    check_val("ignored_start_busy_after", 128'(bus.BUSY), 128'(0));
    read_key("ignored_k1",  4'd1,  FIPS_K1);
    read_key("ignored_k10", 4'd10, FIPS_K10);

    // Reset at cycle 6 of an expansion.
    start_exp(ZERO_KEY);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_all_zero("midreset");
    #3;
    rst_n = 1'b1;
    read_key("midreset_k1_cleared", 4'd1, 128'h0);
    read_key("midreset_k0_cleared", 4'd0, 128'h0);
    start_exp(FIPS_KEY);
    wait_done(cyc);
    read_key("after_reset_k1",  4'd1,  FIPS_K1);
    read_key("after_reset_k10", 4'd10, FIPS_K10);

    // Out-of-range select reads zero.
    read_key("sel15_zero", 4'd15, 128'h0);
    read_key("sel11_zero", 4'd11, 128'h0);

    // Back-to-back: START driven during the DONE cycle.
    start_exp(FIPS_KEY);
    wait_done(cyc);
    bus.IN_KEY = ZERO_KEY;
    bus.START  = 1'b1;
    @(posedge clk); #1;
    bus.START  = 1'b0;
    check_val("b2b_busy",  128'(bus.BUSY),       128'(1));
    check_val("b2b_valid", 128'(bus.KEYS_VALID), 128'(0));
    check_val("b2b_done",  128'(bus.DONE),       128'(0));
    wait_done(cyc);
    check_val("b2b_done_cycle", 128'(cyc + 1), 128'(11));
    read_key("b2b_k1",  4'd1,  ZERO_K1);
    read_key("b2b_k10", 4'd10, ZERO_K10);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global safety bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning the number of AES-128 round keys generated after the initial key.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port START  input  1  one-cycle request to expand IN_KEY.
REQ-005 SHALL have port IN_KEY  input  128  cipher key; bits [127:96] form w0.
REQ-006 SHALL have port KEY_SEL  input  4  round-key index, 0..NUM_ROUNDS.
REQ-007 SHALL have port ROUND_KEY  output  128  registered round key feeding the round stage's IN_KEY.
REQ-008 SHALL have port BUSY  output  1  expansion in progress.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse when the last round key is written.
REQ-010 SHALL have port KEYS_VALID  output  1  full key set stored and stable.

Function
REQ-011 SHALL use FSM states IDLE and EXPAND only.
REQ-012 SHALL accept START only in IDLE: on that edge, IN_KEY goes to key[0], the round counter goes to 1, KEYS_VALID clears, and the state becomes EXPAND.
REQ-013 SHALL compute key[i] from key[i-1] in EXPAND, one key per cycle, on edge START+i for i = 1..NUM_ROUNDS.
REQ-014 SHALL compute each next key per FIPS-197: temp = SubWord(RotWord(w3)) XOR Rcon[i], with w0' = w0^temp, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
REQ-015 SHALL use Rcon = 01,02,04,08,10,20,40,80,1b,36 in the top byte for i = 1..10.
REQ-016 SHALL drive BUSY high from edge START through the edge that writes key[NUM_ROUNDS], i.e. for exactly NUM_ROUNDS+1 cycles after START.
REQ-017 SHALL, on the edge writing key[NUM_ROUNDS], return to IDLE, assert DONE for exactly one cycle and set KEYS_VALID.
REQ-018 SHALL ignore START while in EXPAND, with no restart and no change to the sequence.
REQ-019 SHALL permit START in the same cycle DONE is high; it is accepted because the state is IDLE.
REQ-020 SHALL register ROUND_KEY as key[KEY_SEL] with one-cycle latency, independent of state.
REQ-021 SHALL make ROUND_KEY all-zero when KEY_SEL > NUM_ROUNDS.
REQ-022 SHALL leave stored keys unchanged in IDLE; IN_KEY changes without START have no effect.
REQ-023 SHALL let reads of a key index not yet rewritten during EXPAND return the old value; consumers gate on KEYS_VALID.

Reset
REQ-024 SHALL, on rst_n low and regardless of clock, force state IDLE, counter 0, all key[] zero, ROUND_KEY zero, and BUSY, DONE and KEYS_VALID zero.
REQ-025 SHALL have reset asserted mid-expansion abort the sequence, leaving nothing retained.
REQ-026 SHALL accept no START until after the first rising clk edge following rst_n release.

Structure
REQ-027 SHALL place the Rcon table, NUM_ROUNDS default and FSM state encoding in shared package aes_pkg.
REQ-028 SHALL instantiate sub-module aes_sbox (combinational, 8-bit in/out) four times for SubWord.
REQ-029 SHALL use a single 128-bit-wide register file of NUM_ROUNDS+1 entries and a 4-bit round counter.

Verification
REQ-030 SHALL test the FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> KEY_SEL=1 gives a0fafe1788542cb123a339392a6c7605 and KEY_SEL=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 SHALL test the all-zero key -> KEY_SEL=1 gives 62636363626363636263636362636363 and KEY_SEL=10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-032 SHALL test timing: START at cycle 0 -> BUSY high cycles 1..11, DONE high only at cycle 11, KEYS_VALID high from cycle 11 onward.
REQ-033 SHALL test START pulsed at cycle 4 of an expansion with a different key -> it is ignored and the results match the first key.
REQ-034 SHALL test rst_n low at cycle 6 of an expansion -> all outputs are zero immediately; a fresh START after release yields correct keys.
REQ-035 SHALL test KEY_SEL=15 -> ROUND_KEY is zero one cycle later; back-to-back START on the DONE cycle -> a second expansion is accepted.
